fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Sits between the CPU core and the 16-bit word-addressed `memory` block.
- Owns the program counter and prefetches instructions into a small FIFO, which it presents to decode with a valid/ready handshake.
- Arbitrates the single memory port between instruction fetch and core load/store traffic; data accesses always take priority.
- Supports a branch redirect that flushes the FIFO.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, at least 2).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- redirect  in  1  branch taken; load PC and flush.
- redirect_pc  in  16  new PC for redirect.
- instr_valid  out  1  FIFO head holds a valid instruction.
- instr_ready  in  1  decode accepts the head.
- instr_out  out  16  head instruction word.
- instr_pc  out  16  address of head instruction.
- dreq  in  1  core data access this cycle.
- dwe  in  1  1 = store, 0 = load (qualified by dreq).
- daddr  in  16  data address.
- dwdata  in  16  store data.
- dack  out  1  registered; access from previous cycle is complete.
- drdata  out  16  registered load data.
- MemRead  out  1  to memory MemRead.
- MemWrite  out  1  to memory MemWrite.
- ADDR  out  16  to memory ADDR.
- mem_wdata  out  16  to memory Data_in.
- mem_rdata  in  16  from memory Data_out; valid in the same cycle as MemRead.

Behaviour:
Reset:
- On reset, asynchronously: pc = RESET_PC, FIFO empty (count = 0), dack = 0, drdata = 0.
- While reset is high, MemRead, MemWrite, ADDR, mem_wdata and instr_valid are forced to 0.

Memory-side outputs (combinational from state and inputs, one access per cycle):
- Data access (dreq = 1):
  - MemRead = !dwe, MemWrite = dwe, ADDR = daddr, mem_wdata = dwdata.
  - No fetch this cycle.
- Fetch (dreq = 0, redirect = 0, count < DEPTH):
  - MemRead = 1, MemWrite = 0, ADDR = pc, mem_wdata = 0.
  - At the clock edge, push {pc, mem_rdata} and set pc = pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- Otherwise: MemRead = 0, MemWrite = 0, ADDR = 0, mem_wdata = 0.

Data port:
- dack at edge = dreq.
- drdata captures mem_rdata when dreq & !dwe; otherwise it holds its value.
- Each cycle dreq is high is a separate access, so the requester holds dreq for exactly one cycle per access.
- Latency is one cycle to dack.

Decode handshake:
- instr_valid = (count != 0) & !redirect.
- instr_out and instr_pc show the FIFO head.
- A pop occurs when instr_valid & instr_ready.
- Push and pop in the same cycle leave count unchanged.
- When full, no fetch is issued, even if a pop occurs that cycle. Fetch resumes the next cycle.

Redirect (priority over everything except reset):
- At the edge: FIFO flushed (count = 0), pc = redirect_pc.
- No fetch is issued in the redirect cycle, and no pop is accepted.
- A data access in the same cycle still completes normally.

Starvation:
- Continuous dreq stalls fetch indefinitely. The FIFO drains, then instr_valid drops to 0.

Coherence:
- None. A store to an address already buffered does not update that entry.
- The core must redirect after self-modifying stores.

Reset mid-operation:
- Reset aborts any in-flight state immediately. No partial FIFO or pc state survives.

Decomposition:
- Package fetch_pkg:
  - WORD_W = 16.
  - Default RESET_PC.
  - fetch_entry_t typedef {pc[15:0], instr[15:0]}.
- Sub-module fetch_fifo:
  - Parameterised DEPTH, circular buffer with read/write pointers and count.
  - Ports: push, pop, flush, din, dout, empty, full.
  - Asynchronous reset.
- fetch_unit holds the arbiter, PC and data-port registers.

Test Plan:
1. Reset release, memory preloaded with mem[0] = 16'h27E7, mem[1] = 16'h1111, instr_ready = 1:
   - instr_valid rises the cycle after the first fetch.
   - instr_out = 16'h27E7 with instr_pc = 0, then 16'h1111 with instr_pc = 1.
2. instr_ready = 0 for 10 cycles:
   - Exactly DEPTH (4) fetches occur (pc 0..3).
   - MemRead then stays 0 and count stays at 4.
   - After raising ready, fetching resumes one cycle after the first pop.
3. dreq = 1, dwe = 1, daddr = 5, dwdata = 16'hBEEF, then dreq = 1, dwe = 0, daddr = 5:
   - The fetch is suppressed in both cycles.
   - dack pulses in both following cycles.
   - drdata = 16'hBEEF after the load.
4. With 3 entries buffered, redirect = 1 and redirect_pc = 16'h0008 while instr_ready = 1:
   - instr_valid = 0 that cycle and count = 0 after the edge.
   - The next fetch uses ADDR = 8.
   - No instruction from the old stream is presented.
5. Set pc = 16'hFFFF via redirect:
   - Fetches go to ADDR = 16'hFFFF, then 16'h0000.
   - instr_pc values are 16'hFFFF, then 16'h0000.
6. Assert reset asynchronously mid-fetch, with FIFO partially full and dack = 1:
   - All outputs are 0 immediately, before the next clock edge.
   - After release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [2*WORD_W-1:0]   din,
  output logic [2*WORD_W-1:0]   dout,
  output logic                  empty,
  output logic                  full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2*WORD_W-1:0] buffer [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                push_ok;
  logic                pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push & !full;
  assign pop_ok  = pop & !empty;
  assign dout    = buffer[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) buffer[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// PC, prefetch buffer and single-port memory arbiter; data accesses win over fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [15:0] daddr,
  input  logic [15:0] dwdata,
  output logic        dack,
  output logic [15:0] drdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [15:0] ADDR,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);
  logic [WORD_W-1:0] pc;
  logic              fetch;
  logic              pop;
  logic              empty;
  logic              full;
  fetch_entry_t      head;
  fetch_entry_t      fill;
  logic [2*WORD_W-1:0] head_bits;

  assign fill = '{pc: pc, instr: mem_rdata};
  assign head = head_bits;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (reset),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect),
    .din   (fill),
    .dout  (head_bits),
    .empty (empty),
    .full  (full)
  );

  // Fullness is judged before any same-cycle pop, so a full buffer skips one fetch slot.
  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ADDR      = '0;
    mem_wdata = '0;
    fetch     = 1'b0;
    if (!reset) begin
      if (dreq) begin
        MemRead   = !dwe;
        MemWrite  = dwe;
        ADDR      = daddr;
        mem_wdata = dwdata;
      end else if (!redirect && !full) begin
        fetch   = 1'b1;
        MemRead = 1'b1;
        ADDR    = pc;
      end
    end
  end

  assign instr_valid = !reset && !empty && !redirect;
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = reset ? '0 : head.instr;
  assign instr_pc    = reset ? '0 : head.pc;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      dack   <= 1'b0;
      drdata <= '0;
    end else begin
      dack <= dreq;
      if (dreq && !dwe) drdata <= mem_rdata;
      if (redirect)   pc <= redirect_pc;
      else if (fetch) pc <= pc + 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with instruction and data-port scoreboards.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        dreq;
  logic        dwe;
  logic [15:0] daddr;
  logic [15:0] dwdata;
  logic        dack;
  logic [15:0] drdata;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] ADDR;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] iexp_q[$];
  logic [15:0] dexp_q[$];

  bit [15:0] mem [0:65535];
  bit        mem_written [0:65535];

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .dack(dack), .drdata(drdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .ADDR(ADDR), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Memory image: two fixed words at 0/1, address ^ 16'h5A5A elsewhere, stores overlay it.
  function automatic logic [15:0] base_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h27E7;
    if (a == 16'h0001) return 16'h1111;
    return a ^ 16'h5A5A;
  endfunction

  assign mem_rdata = mem_written[ADDR] ? mem[ADDR] : base_word(ADDR);

  always @(posedge CLK) begin
    if (MemWrite) begin
      mem[ADDR]         <= mem_wdata;
      mem_written[ADDR] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  initial forever begin
    @(negedge CLK);
    if (!reset && instr_valid && instr_ready) begin
      if (iexp_q.size() == 0) check("unexpected_instr", {instr_pc, instr_out}, 32'hxxxx_xxxx);
      else check("instr_head", {instr_pc, instr_out}, iexp_q.pop_front());
    end
  end

  initial forever begin
    @(negedge CLK);
    if (!reset && dack) begin
      if (dexp_q.size() == 0) check("unexpected_dack", {16'h0, drdata}, 32'hxxxx_xxxx);
      else check("drdata", {16'h0, drdata}, {16'h0, dexp_q.pop_front()});
    end
  end

  initial begin
    int nf;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    dreq = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
    repeat (2) next_cycle();
    @(negedge CLK);
    check("rst_memread", {31'h0, MemRead}, 32'h0);
    check("rst_addr", {16'h0, ADDR}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_dack_drdata", {15'h0, dack, drdata}, 32'h0);

    // Test 1: streaming from reset with decode always ready
    next_cycle();
    reset = 1'b0; instr_ready = 1'b1;
    iexp_q.push_back({16'h0000, 16'h27E7});
    iexp_q.push_back({16'h0001, 16'h1111});
    @(negedge CLK);
    check("t1_first_fetch", {14'h0, instr_valid, MemRead, ADDR}, {14'h0, 1'b0, 1'b1, 16'h0000});
    next_cycle();
    @(negedge CLK);
    check("t1_valid_next", {14'h0, instr_valid, MemRead, ADDR}, {14'h0, 1'b1, 1'b1, 16'h0001});
    next_cycle();
    next_cycle();
    instr_ready = 1'b0; reset = 1'b1;
    @(negedge CLK);
    check("t2_rst_valid", {31'h0, instr_valid}, 32'h0);

    // Test 2: decode stalled, buffer fills to DEPTH and fetch stops
    next_cycle();
    reset = 1'b0;
    nf = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (MemRead) begin
        check("t2_fetch_addr", {16'h0, ADDR}, nf);
        nf++;
      end
      next_cycle();
    end
    check("t2_fetch_count", nf, 4);
    instr_ready = 1'b1;
    iexp_q.push_back({16'h0000, 16'h27E7});
    iexp_q.push_back({16'h0001, 16'h1111});
    @(negedge CLK);
    check("t2_full_pop_nofetch", {30'h0, instr_valid, MemRead}, {30'h0, 1'b1, 1'b0});
    next_cycle();
    @(negedge CLK);
    check("t2_resume", {15'h0, MemRead, ADDR}, {15'h0, 1'b1, 16'h0004});

    // Test 3: store then load to address 5
    next_cycle();
    instr_ready = 1'b0; dreq = 1'b1; dwe = 1'b1; daddr = 16'h0005; dwdata = 16'hBEEF;
    dexp_q.push_back(16'h0000);
    @(negedge CLK);
    check("t3_store_ctl", {14'h0, MemRead, MemWrite, ADDR}, {14'h0, 1'b0, 1'b1, 16'h0005});
    check("t3_store_wdata", {16'h0, mem_wdata}, {16'h0, 16'hBEEF});
    next_cycle();
    dwe = 1'b0; dwdata = '0;
    dexp_q.push_back(16'hBEEF);
    @(negedge CLK);
    check("t3_load_ctl", {14'h0, MemRead, MemWrite, ADDR}, {14'h0, 1'b1, 1'b0, 16'h0005});
    next_cycle();
    dreq = 1'b0; daddr = '0;
    @(negedge CLK);
    check("t3_pc_held", {15'h0, MemRead, ADDR}, {15'h0, 1'b1, 16'h0005});
    next_cycle();
    instr_ready = 1'b1;
    iexp_q.push_back({16'h0002, 16'h5A58});
    @(negedge CLK);
    check("t3_full_nofetch", {31'h0, MemRead}, 32'h0);

    // Test 4: redirect to 8 with 3 entries buffered
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0008;
    @(negedge CLK);
    check("t4_redirect_cycle", {30'h0, instr_valid, MemRead}, 32'h0);
    next_cycle();
    redirect = 1'b0;
    iexp_q.push_back({16'h0008, 16'h5A52});
    @(negedge CLK);
    check("t4_after_flush", {14'h0, instr_valid, MemRead, ADDR}, {14'h0, 1'b0, 1'b1, 16'h0008});

    // Test 5: wrap of pc through 16'hFFFF
    next_cycle();
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge CLK);
    check("t5_redirect_cycle", {31'h0, instr_valid}, 32'h0);
    next_cycle();
    redirect = 1'b0;
    iexp_q.push_back({16'hFFFF, 16'hA5A5});
    @(negedge CLK);
    check("t5_fetch_ffff", {15'h0, MemRead, ADDR}, {15'h0, 1'b1, 16'hFFFF});
    next_cycle();
    @(negedge CLK);
    check("t5_fetch_wrap", {15'h0, MemRead, ADDR}, {15'h0, 1'b1, 16'h0000});

    // Test 6: asynchronous reset during a fetch with dack high
    next_cycle();
    instr_ready = 1'b0; dreq = 1'b1; dwe = 1'b0; daddr = 16'h0001;
    dexp_q.push_back(16'h1111);
    next_cycle();
    dreq = 1'b0; daddr = '0;
    @(negedge CLK);
    #2;
    check("t6_pre_state", {13'h0, dack, instr_valid, MemRead, ADDR}, {13'h0, 3'b111, 16'h0001});
    reset = 1'b1;
    #1;
    check("t6_mem_outs", {MemRead, MemWrite, ADDR, mem_wdata[13:0]}, 32'h0);
    check("t6_mem_wdata_hi", {30'h0, mem_wdata[15:14]}, 32'h0);
    check("t6_dack_valid", {30'h0, dack, instr_valid}, 32'h0);
    check("t6_drdata", {16'h0, drdata}, 32'h0);
    check("t6_head", {instr_pc, instr_out}, 32'h0);
    next_cycle();
    reset = 1'b0; instr_ready = 1'b1;
    iexp_q.push_back({16'h0000, 16'h27E7});
    @(negedge CLK);
    check("t6_first_fetch", {14'h0, instr_valid, MemRead, ADDR}, {14'h0, 1'b0, 1'b1, 16'h0000});
    next_cycle();
    next_cycle();
    instr_ready = 1'b0;
    repeat (3) next_cycle();
    check("instr_queue_drained", iexp_q.size(), 0);
    check("data_queue_drained", dexp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
